// File: rtl/skein_host_if_param.sv
// Host-side bus interface for the Skein core: streams a length header and message
// blocks in from a narrow host bus, kicks the core, and serialises the digest back out.
module skein_host_if_param #(
    parameter int IO_W       = 16,
    parameter int WORD_W     = 32,
    parameter int MSG_WORDS  = 8,
    parameter int HASH_WORDS = 8,
    parameter int LEN_BEATS  = 4,
    parameter int BYTE_SWAP  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init,
    input  logic                         load,
    input  logic                         fetch,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IO_W-1:0]              in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IO_W-1:0]              out_data,
    output logic [MSG_WORDS*WORD_W-1:0]  msg_block,
    output logic [LEN_BEATS*IO_W-1:0]    len_o,
    output logic                         ld_posi,
    output logic                         ld_tweak,
    output logic                         start,
    input  logic                         busy,
    input  logic [HASH_WORDS*WORD_W-1:0] hash,
    output logic                         err
);

    localparam int BPW        = WORD_W / IO_W;
    localparam int BLK_BEATS  = MSG_WORDS * BPW;
    localparam int HASH_BEATS = HASH_WORDS * WORD_W / IO_W;
    localparam int MAX_AB     = (BLK_BEATS > HASH_BEATS) ? BLK_BEATS : HASH_BEATS;
    localparam int MAX_BEATS  = (MAX_AB > LEN_BEATS) ? MAX_AB : LEN_BEATS;
    localparam int CNT_W      = $clog2(MAX_BEATS + 1);
    localparam int NB         = IO_W / 8;
    localparam int LEN_W      = LEN_BEATS * IO_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_START,
        S_WAIT,
        S_FETCH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               hdr_done;
    logic               wait_armed;
    logic [CNT_W-1:0]   beat_sel;
    logic [IO_W-1:0]    beat_raw;
    logic [IO_W-1:0]    next_beat;

    function automatic logic [IO_W-1:0] swap_bytes(input logic [IO_W-1:0] w);
        logic [IO_W-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[i*8 +: 8] = w[(NB-1-i)*8 +: 8];
        end
        return r;
    endfunction

    assign in_ready  = (state == S_HDR) || (state == S_LOAD);
    assign out_valid = (state == S_FETCH);
    assign start     = (state == S_START);
    assign ld_tweak  = (state == S_START);
    assign ld_posi   = (state == S_HDR) && in_valid;

    // Digest beat to present next: beat 0 when entering FETCH, else the one after the current.
    always_comb begin
        beat_sel = (state == S_FETCH) ? cnt + CNT_W'(1) : '0;
        beat_raw = '0;
        for (int j = 0; j < HASH_BEATS; j++) begin
            if (beat_sel == CNT_W'(j)) begin
                beat_raw = hash[j*IO_W +: IO_W];
            end
        end
        next_beat = (BYTE_SWAP != 0) ? swap_bytes(beat_raw) : beat_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hdr_done   <= 1'b0;
            wait_armed <= 1'b0;
            msg_block  <= '0;
            len_o      <= '0;
            out_data   <= '0;
            err        <= 1'b0;
        end else if (init) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hdr_done   <= 1'b0;
            wait_armed <= 1'b0;
            msg_block  <= '0;
            len_o      <= '0;
            out_data   <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (load) begin
                        state <= hdr_done ? S_LOAD : S_HDR;
                    end else if (fetch) begin
                        state    <= S_FETCH;
                        out_data <= next_beat;
                    end
                end
                S_HDR: begin
                    if (fetch) begin
                        err <= 1'b1;
                    end
                    if (in_valid) begin
                        len_o <= (len_o << IO_W) | LEN_W'(in_data);
                        if (cnt == CNT_W'(LEN_BEATS - 1)) begin
                            cnt      <= '0;
                            hdr_done <= 1'b1;
                            state    <= S_LOAD;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_LOAD: begin
                    if (fetch) begin
                        err <= 1'b1;
                    end
                    if (in_valid) begin
                        // First beat of each word lands in its most significant slice.
                        for (int b = 0; b < BLK_BEATS; b++) begin
                            if (cnt == CNT_W'(b)) begin
                                msg_block[(b / BPW) * WORD_W + (BPW - 1 - (b % BPW)) * IO_W +: IO_W] <= in_data;
                            end
                        end
                        if (cnt == CNT_W'(BLK_BEATS - 1)) begin
                            cnt   <= '0;
                            state <= S_START;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_START: begin
                    cnt        <= '0;
                    wait_armed <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (load || fetch) begin
                        err <= 1'b1;
                    end
                    // The core may not have raised busy yet in the first WAIT cycle.
                    wait_armed <= 1'b1;
                    if (wait_armed && !busy) begin
                        wait_armed <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (out_ready) begin
                        if (cnt == CNT_W'(HASH_BEATS - 1)) begin
                            cnt      <= '0;
                            hdr_done <= 1'b0;
                            out_data <= '0;
                            state    <= S_IDLE;
                        end else begin
                            cnt      <= cnt + CNT_W'(1);
                            out_data <= next_beat;
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skein_host_if_param.sv
// Directed bench for skein_host_if_param at default parameters.
module tb_skein_host_if_param;

    localparam int IO_W = 16;
    localparam int WORD_W = 32;
    localparam int MSG_WORDS = 8;
    localparam int HASH_WORDS = 8;
    localparam int LEN_BEATS = 4;

    logic clk = 1'b0;
    logic rst_n, init, load, fetch, in_valid, out_ready, busy;
    logic [IO_W-1:0] in_data;
    logic in_ready, out_valid, ld_posi, ld_tweak, start, err;
    logic [IO_W-1:0] out_data;
    logic [MSG_WORDS*WORD_W-1:0] msg_block;
    logic [LEN_BEATS*IO_W-1:0] len_o;
    logic [HASH_WORDS*WORD_W-1:0] hash;

    int tests_run = 0;
    int tests_failed = 0;
    int start_cnt = 0;
    int pair_cnt = 0;
    int posi_cnt = 0;

    logic [IO_W-1:0] exp_beat [16];

    skein_host_if_param dut (
        .clk(clk), .rst_n(rst_n), .init(init), .load(load), .fetch(fetch),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .msg_block(msg_block), .len_o(len_o), .ld_posi(ld_posi),
        .ld_tweak(ld_tweak), .start(start), .busy(busy), .hash(hash), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start) start_cnt++;
        if (start && ld_tweak) pair_cnt++;
        if (ld_posi) posi_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [IO_W-1:0] d);
        int n;
        n = 0;
        in_data = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 256'(in_ready), 256'(1));
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int p0, s0, j, n;
        logic [IO_W-1:0] hw;
        rst_n = 0; init = 0; load = 0; fetch = 0; in_valid = 0;
        out_ready = 0; busy = 0; in_data = '0;
        for (int k = 0; k < HASH_WORDS; k++)
            hash[k*WORD_W +: WORD_W] = (k == 0) ? 32'h11223344 : 32'hA0B0C0D0 + 32'(k);
        for (int b = 0; b < 16; b++) begin
            hw = hash[b*IO_W +: IO_W];
            exp_beat[b] = {hw[7:0], hw[15:8]};
        end
        repeat (3) tick();
        rst_n = 1;

        // 1: reset / idle
        repeat (5) tick();
        @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_ctrl", 256'({start, ld_tweak, ld_posi, err}), 256'(0));
        chk("rst_msg", 256'(msg_block), 256'(0));
        chk("rst_len", 256'(len_o), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        tick();

        // 2: header + first block
        init = 1; tick(); init = 0;
        load = 1; tick(); load = 0;
        p0 = posi_cnt;
        send_beat(16'h0000); send_beat(16'h0000); send_beat(16'h0000); send_beat(16'h0040);
        chk("hdr_posi", 256'(posi_cnt - p0), 256'(4));
        chk("hdr_len", 256'(len_o), 256'(64'h40));
        for (int b = 1; b <= 16; b++) send_beat(16'(b));
        @(negedge clk);
        chk("start_pulse", 256'({start, ld_tweak}), 256'(2'b11));
        tick();
        @(negedge clk);
        chk("start_single", 256'({start, ld_tweak}), 256'(0));
        chk("blk1_word0", 256'(msg_block[31:0]), 256'(32'h00010002));
        chk("blk1_word7", 256'(msg_block[255:224]), 256'(32'h000F0010));
        repeat (3) tick();
        chk("start_cnt1", 256'(start_cnt), 256'(1));
        chk("pair_cnt1", 256'(pair_cnt), 256'(1));

        // 3: second block goes straight to LOAD
        p0 = posi_cnt;
        load = 1; tick(); load = 0;
        for (int b = 0; b < 16; b++) send_beat(16'h0100 + 16'(b));
        chk("blk2_no_posi", 256'(posi_cnt - p0), 256'(0));
        chk("blk2_word0", 256'(msg_block[31:0]), 256'(32'h01000101));
        chk("blk2_word7", 256'(msg_block[255:224]), 256'(32'h010E010F));

        // 4: busy held for 5 cycles, load during WAIT flags err
        tick();
        busy = 1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            load = (i == 1);
            @(negedge clk);
            if (in_ready) n++;
            tick();
        end
        load = 0;
        busy = 0;
        chk("wait_in_ready", 256'(n), 256'(0));
        chk("wait_err", 256'(err), 256'(1));
        chk("start_cnt2", 256'(start_cnt), 256'(2));
        chk("wait_msg_stable", 256'(msg_block[31:0]), 256'(32'h01000101));
        tick();
        fetch = 1; tick(); fetch = 0;
        @(negedge clk);
        chk("idle_after_busy", 256'(out_valid), 256'(1));

        // 5: digest readout with toggling out_ready
        chk("beat0_const", 256'(exp_beat[0]), 256'(16'h4433));
        chk("beat1_const", 256'(exp_beat[1]), 256'(16'h2211));
        j = 0;
        n = 0;
        while (j < 16 && n < 100) begin
            if (out_valid) begin
                chk($sformatf("beat%0d", j), 256'(out_data), 256'(exp_beat[j]));
                if (out_ready) j++;
            end
            tick();
            out_ready = ~out_ready;
            n++;
            @(negedge clk);
        end
        chk("fetch_beats", 256'(j), 256'(16));
        chk("fetch_done", 256'(out_valid), 256'(0));
        out_ready = 0;
        tick();
        p0 = posi_cnt;
        load = 1; tick(); load = 0;
        send_beat(16'h0000); send_beat(16'h0000); send_beat(16'h0000); send_beat(16'h0080);
        chk("rehdr_posi", 256'(posi_cnt - p0), 256'(4));
        chk("rehdr_len", 256'(len_o), 256'(64'h80));

        // 6: init in the middle of a block load
        for (int b = 0; b < 5; b++) send_beat(16'h0200 + 16'(b));
        s0 = start_cnt;
        init = 1; tick(); init = 0;
        @(negedge clk);
        chk("init_in_ready", 256'(in_ready), 256'(0));
        chk("init_msg", 256'(msg_block), 256'(0));
        chk("init_len", 256'(len_o), 256'(0));
        chk("init_err", 256'(err), 256'(0));
        repeat (20) tick();
        chk("init_no_start", 256'(start_cnt), 256'(s0));
        p0 = posi_cnt;
        load = 1; tick(); load = 0;
        send_beat(16'h1234);
        chk("init_rehdr", 256'(posi_cnt - p0), 256'(1));

        // async reset mid-header
        rst_n = 0;
        #1;
        chk("arst_in_ready", 256'(in_ready), 256'(0));
        chk("arst_len", 256'(len_o), 256'(0));
        tick();
        rst_n = 1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
